// File: rtl/eth_rx_pkg.sv
// Shared encodings and constants for the RMII receive path, plus the
// byte-wise reflected CRC-32 step used by the FCS checker.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_HEADER   = 3'd2,
    ST_DATA     = 3'd3,
    ST_DROP     = 3'd4,
    ST_DONE     = 3'd5
  } rx_state_t;

  localparam int          pMII_WIDTH      = 2;
  localparam logic [31:0] pCRC_INIT       = 32'hFFFFFFFF;
  localparam logic [31:0] pCRC_POLY       = 32'hEDB88320;
  localparam logic [31:0] pCRC_RESIDUE    = 32'hDEBB20E3;
  localparam logic [10:0] pMIN_FRAME      = 11'd64;
  localparam logic [10:0] pMAX_FRAME      = 11'd1518;
  localparam logic [10:0] pBYTE_CNT_MAX   = 11'h7FF;
  localparam logic [10:0] pOFS_DEST_FIRST = 11'd0;
  localparam logic [10:0] pOFS_DEST_LAST  = 11'd5;
  localparam logic [10:0] pOFS_LEN_HI     = 11'd12;
  localparam logic [10:0] pOFS_LEN_LO     = 11'd13;
  localparam logic [1:0]  pDIBIT_PRE      = 2'b01;
  localparam logic [1:0]  pDIBIT_SFD      = 2'b11;
  localparam logic [5:0]  pPRE_CNT_MAX    = 6'h3F;

  // One byte through the reflected CRC-32, LSB first; no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ pCRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_if.sv
// RMII receive pins in, payload stream and frame status out.
interface eth_rx_if;

  logic [eth_rx_pkg::pMII_WIDTH-1:0] Rxd;
  logic                              Crs_Dv;
  logic [7:0]                        Rx_Byte;
  logic                              Rx_Byte_Valid;
  logic [15:0]                       Rx_Len_Type;
  logic                              Rx_Pkt_Done;
  logic                              Rx_Pkt_Err;

  modport master (
    input  Rxd, Crs_Dv,
    output Rx_Byte, Rx_Byte_Valid, Rx_Len_Type, Rx_Pkt_Done, Rx_Pkt_Err
  );

  modport slave (
    output Rxd, Crs_Dv,
    input  Rx_Byte, Rx_Byte_Valid, Rx_Len_Type, Rx_Pkt_Done, Rx_Pkt_Err
  );

endinterface

// File: rtl/eth_crc_gen.sv
// Byte-serial Ethernet CRC-32 register, shared by the transmit and receive paths.
module eth_crc_gen
  import eth_rx_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Crc_Init,
  input  logic        Crc_Req,
  input  logic        Byte_Rdy,
  input  logic [7:0]  Data_In,
  output logic [31:0] Crc_Out
);

  always_ff @(posedge Clk) begin
    if (Rst || Crc_Init) begin
      Crc_Out <= pCRC_INIT;
    end else if (Crc_Req && Byte_Rdy) begin
      Crc_Out <= crc32_byte(Crc_Out, Data_In);
    end
  end

endmodule

// File: rtl/eth_rx.sv
// RMII receive datapath: preamble/SFD hunt, destination filter, header strip,
// 4-byte FCS holdback and end-of-frame status reporting.
//
// state    | meaning
// IDLE     | carrier off, CRC held at init
// PREAMBLE | counting 01 dibits, waiting for SFD
// HEADER   | bytes 0-13: address filter, length/type capture
// DATA     | payload through the 4-byte delay line
// DROP     | frame rejected, wait for carrier off
// DONE     | one-cycle status pulse
module eth_rx
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] pMAC_ADDR       = 48'h020000000001,
  parameter bit          pPROMISC        = 1'b0,
  parameter int unsigned pMIN_PRE_DIBITS = 8
) (
  input logic      Clk,
  input logic      Rst,
  eth_rx_if.master rx
);

  localparam logic [5:0] MIN_PRE = 6'(pMIN_PRE_DIBITS);

  rx_state_t   state, state_nxt;
  logic [1:0]  rxd_q;
  logic        crs_q;
  logic [5:0]  pre_cnt;
  logic [1:0]  dib_cnt;
  logic [7:0]  sr;
  logic [10:0] byte_cnt;
  logic        match_uc, match_bc, addr_ok;
  logic [15:0] len_q;
  logic [7:0]  dl [4];
  logic [2:0]  dl_cnt;

  logic        in_frame, byte_done, crc_init;
  logic [7:0]  byte_new, mac_byte;
  logic        uc_nxt, bc_nxt, addr_hit, frame_err;
  logic [31:0] crc;

  assign in_frame  = (state == ST_HEADER) || (state == ST_DATA);
  assign byte_done = in_frame && crs_q && (dib_cnt == 2'd3);
  assign byte_new  = {rxd_q, sr[7:2]};
  assign crc_init  = (state == ST_IDLE);

  always_comb begin
    mac_byte = 8'h00;
    case (byte_cnt[2:0])
      3'd0:    mac_byte = pMAC_ADDR[47:40];
      3'd1:    mac_byte = pMAC_ADDR[39:32];
      3'd2:    mac_byte = pMAC_ADDR[31:24];
      3'd3:    mac_byte = pMAC_ADDR[23:16];
      3'd4:    mac_byte = pMAC_ADDR[15:8];
      3'd5:    mac_byte = pMAC_ADDR[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  // Running match flags; byte 0 seeds them, later bytes can only clear them.
  always_comb begin
    uc_nxt   = (byte_new == mac_byte) && ((byte_cnt == pOFS_DEST_FIRST) || match_uc);
    bc_nxt   = (byte_new == 8'hFF)    && ((byte_cnt == pOFS_DEST_FIRST) || match_bc);
    addr_hit = uc_nxt || bc_nxt || pPROMISC;
  end

  assign frame_err = (state == ST_HEADER)
                  || (crc != pCRC_RESIDUE)
                  || (byte_cnt < pMIN_FRAME)
                  || (byte_cnt > pMAX_FRAME)
                  || (dib_cnt != 2'd0);

  eth_crc_gen u_crc (
    .Clk      (Clk),
    .Rst      (Rst),
    .Crc_Init (crc_init),
    .Crc_Req  (in_frame),
    .Byte_Rdy (byte_done),
    .Data_In  (byte_new),
    .Crc_Out  (crc)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (crs_q) state_nxt = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (!crs_q) begin
          state_nxt = ST_IDLE;
        end else if (rxd_q == pDIBIT_SFD) begin
          state_nxt = (pre_cnt >= MIN_PRE) ? ST_HEADER : ST_DROP;
        end else if (rxd_q == pDIBIT_PRE) begin
          state_nxt = ST_PREAMBLE;
        end else if ((rxd_q == 2'b00) && (pre_cnt == 6'd0)) begin
          state_nxt = ST_PREAMBLE;
        end else begin
          state_nxt = ST_DROP;
        end
      end
      ST_HEADER: begin
        if (!crs_q) begin
          state_nxt = addr_ok ? ST_DONE : ST_DROP;
        end else if (byte_done && (byte_cnt == pOFS_DEST_LAST) && !addr_hit) begin
          state_nxt = ST_DROP;
        end else if (byte_done && (byte_cnt == pOFS_LEN_LO)) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!crs_q) state_nxt = ST_DONE;
      end
      ST_DROP: begin
        if (!crs_q) state_nxt = ST_IDLE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rxd_q            <= '0;
      crs_q            <= 1'b0;
      pre_cnt          <= '0;
      dib_cnt          <= '0;
      sr               <= '0;
      byte_cnt         <= '0;
      match_uc         <= 1'b0;
      match_bc         <= 1'b0;
      addr_ok          <= 1'b0;
      len_q            <= '0;
      dl_cnt           <= '0;
      for (int i = 0; i < 4; i++) dl[i] <= '0;
      rx.Rx_Byte       <= '0;
      rx.Rx_Byte_Valid <= 1'b0;
      rx.Rx_Len_Type   <= '0;
      rx.Rx_Pkt_Done   <= 1'b0;
      rx.Rx_Pkt_Err    <= 1'b0;
    end else begin
      rxd_q            <= rx.Rxd;
      crs_q            <= rx.Crs_Dv;
      rx.Rx_Byte_Valid <= 1'b0;
      rx.Rx_Pkt_Done   <= 1'b0;
      rx.Rx_Pkt_Err    <= 1'b0;

      case (state)
        ST_IDLE: begin
          pre_cnt <= (crs_q && (rxd_q == pDIBIT_PRE)) ? 6'd1 : 6'd0;
        end
        ST_PREAMBLE: begin
          if ((rxd_q == pDIBIT_PRE) && (pre_cnt != pPRE_CNT_MAX)) pre_cnt <= pre_cnt + 6'd1;
          dib_cnt  <= '0;
          byte_cnt <= '0;
          dl_cnt   <= '0;
          addr_ok  <= 1'b0;
          len_q    <= '0;
        end
        ST_HEADER, ST_DATA: begin
          if (crs_q) begin
            sr      <= byte_new;
            dib_cnt <= dib_cnt + 2'd1;
          end
          if (byte_done) begin
            if (byte_cnt != pBYTE_CNT_MAX) byte_cnt <= byte_cnt + 11'd1;
            if (state == ST_HEADER) begin
              if (byte_cnt <= pOFS_DEST_LAST) begin
                match_uc <= uc_nxt;
                match_bc <= bc_nxt;
              end
              if (byte_cnt == pOFS_DEST_LAST) addr_ok <= addr_hit;
              if (byte_cnt == pOFS_LEN_HI) len_q[15:8] <= byte_new;
              if (byte_cnt == pOFS_LEN_LO) len_q[7:0] <= byte_new;
            end else begin
              // Four bytes of holdback means the FCS never reaches the output.
              dl[0] <= byte_new;
              dl[1] <= dl[0];
              dl[2] <= dl[1];
              dl[3] <= dl[2];
              if (dl_cnt == 3'd4) begin
                rx.Rx_Byte       <= dl[3];
                rx.Rx_Byte_Valid <= 1'b1;
              end else begin
                dl_cnt <= dl_cnt + 3'd1;
              end
            end
          end
        end
        default: ;
      endcase

      if (state_nxt == ST_DONE) begin
        rx.Rx_Pkt_Done <= 1'b1;
        rx.Rx_Pkt_Err  <= frame_err;
        rx.Rx_Len_Type <= len_q;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx.sv
// Directed frames into two receivers (filtered and promiscuous) with
// hand-built frames and a bench-side FCS calculation.
module tb_eth_rx;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [1:0] rxd = 2'b00;
  logic       crs = 1'b0;

  always #10 Clk = ~Clk;

  eth_rx_if rx_if ();
  eth_rx_if rxp_if ();

  assign rx_if.Rxd     = rxd;
  assign rx_if.Crs_Dv  = crs;
  assign rxp_if.Rxd    = rxd;
  assign rxp_if.Crs_Dv = crs;

  eth_rx #(.pMAC_ADDR(48'h020000000001), .pPROMISC(1'b0), .pMIN_PRE_DIBITS(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .rx  (rx_if)
  );

  eth_rx #(.pMAC_ADDR(48'h020000000001), .pPROMISC(1'b1), .pMIN_PRE_DIBITS(8)) dut_p (
    .Clk (Clk),
    .Rst (Rst),
    .rx  (rxp_if)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] frm [0:127];
  int         frm_len = 0;

  logic [7:0] got   [0:2047];
  logic [7:0] got_p [0:2047];
  int n = 0, n_p = 0, dones = 0, dones_p = 0, errs = 0, errs_p = 0;
  int b_n, b_np, b_d, b_dp, b_e, b_ep;

  always @(negedge Clk) begin
    if (rx_if.Rx_Byte_Valid) begin
      if (n < 2048) got[n] = rx_if.Rx_Byte;
      n++;
    end
    if (rxp_if.Rx_Byte_Valid) begin
      if (n_p < 2048) got_p[n_p] = rxp_if.Rx_Byte;
      n_p++;
    end
    if (rx_if.Rx_Pkt_Done) begin
      dones++;
      if (rx_if.Rx_Pkt_Err) errs++;
    end
    if (rxp_if.Rx_Pkt_Done) begin
      dones_p++;
      if (rxp_if.Rx_Pkt_Err) errs_p++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    b_n = n; b_np = n_p; b_d = dones; b_dp = dones_p; b_e = errs; b_ep = errs_p;
  endtask

  function automatic int count_bad(input bit prom, input int base, input int cnt, input int plen);
    int bad;
    logic [7:0] v;
    bad = 0;
    for (int i = 0; i < cnt; i++) begin
      if (base + i < 2048) begin
        v = prom ? got_p[base + i] : got[base + i];
        if (v !== 8'(i % plen)) bad++;
      end
    end
    return bad;
  endfunction

  task automatic build(input logic [47:0] dest, input int plen, input bit bad_fcs);
    logic [47:0] src;
    logic [31:0] c;
    logic [7:0]  b;
    src = 48'h020000000002;
    for (int i = 0; i < 6; i++) begin
      frm[i]     = dest[8*(5-i) +: 8];
      frm[6 + i] = src[8*(5-i) +: 8];
    end
    frm[12] = 8'h08;
    frm[13] = 8'h00;
    for (int i = 0; i < plen; i++) frm[14 + i] = 8'(i);
    frm_len = 14 + plen;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < frm_len; i++) begin
      b = frm[i];
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB88320;
        else             c = c >> 1;
      end
    end
    c = ~c;
    for (int k = 0; k < 4; k++) frm[frm_len + k] = c[8*k +: 8];
    if (bad_fcs) frm[frm_len + 3] = frm[frm_len + 3] ^ 8'h01;
    frm_len = frm_len + 4;
  endtask

  task automatic drive(input logic [1:0] d);
    @(negedge Clk);
    crs = 1'b1;
    rxd = d;
  endtask

  task automatic send_frame(input int pre, input int extra, input int abort_at, input int ifg);
    logic [7:0] b;
    for (int p = 0; p < pre; p++) drive(2'b01);
    drive(2'b11);
    for (int i = 0; i < frm_len; i++) begin
      if (i == abort_at) begin
        @(negedge Clk);
        Rst = 1'b1; crs = 1'b0; rxd = 2'b00;
        @(negedge Clk);
        Rst = 1'b0;
        return;
      end
      b = frm[i];
      for (int k = 0; k < 4; k++) drive(b[2*k +: 2]);
    end
    for (int e = 0; e < extra; e++) drive(2'b01);
    @(negedge Clk);
    crs = 1'b0;
    rxd = 2'b00;
    repeat (ifg) @(negedge Clk);
  endtask

  initial begin
    repeat (4) @(negedge Clk);
    Rst = 1'b0;
    chk("rst_byte",  32'(rx_if.Rx_Byte), 32'h0);
    chk("rst_valid", 32'(rx_if.Rx_Byte_Valid), 32'h0);
    chk("rst_len",   32'(rx_if.Rx_Len_Type), 32'h0);
    chk("rst_done",  32'(rx_if.Rx_Pkt_Done), 32'h0);
    chk("rst_err",   32'(rx_if.Rx_Pkt_Err), 32'h0);
    chk("rst_crc",   dut.u_crc.Crc_Out, 32'hFFFFFFFF);
    repeat (4) @(negedge Clk);

    // Broadcast frame, 46-byte payload, good FCS
    build(48'hFFFFFFFFFFFF, 46, 1'b0);
    mark();
    send_frame(31, 0, -1, 20);
    chk("bc_count",   32'(n - b_n), 32'd46);
    chk("bc_bytes",   32'(count_bad(1'b0, b_n, 46, 46)), 32'd0);
    chk("bc_done",    32'(dones - b_d), 32'd1);
    chk("bc_err",     32'(errs - b_e), 32'd0);
    chk("bc_len",     32'(rx_if.Rx_Len_Type), 32'h0800);
    chk("bc_p_count", 32'(n_p - b_np), 32'd46);
    chk("bc_p_done",  32'(dones_p - b_dp), 32'd1);

    // Last FCS byte corrupted
    build(48'hFFFFFFFFFFFF, 46, 1'b1);
    mark();
    send_frame(31, 0, -1, 20);
    chk("fcs_count", 32'(n - b_n), 32'd46);
    chk("fcs_bytes", 32'(count_bad(1'b0, b_n, 46, 46)), 32'd0);
    chk("fcs_done",  32'(dones - b_d), 32'd1);
    chk("fcs_err",   32'(errs - b_e), 32'd1);

    // Foreign unicast address: filtered vs promiscuous
    build(48'h020000000003, 46, 1'b0);
    mark();
    send_frame(31, 0, -1, 20);
    chk("uc_count",   32'(n - b_n), 32'd0);
    chk("uc_done",    32'(dones - b_d), 32'd0);
    chk("uc_p_count", 32'(n_p - b_np), 32'd46);
    chk("uc_p_bytes", 32'(count_bad(1'b1, b_np, 46, 46)), 32'd0);
    chk("uc_p_done",  32'(dones_p - b_dp), 32'd1);
    chk("uc_p_err",   32'(errs_p - b_ep), 32'd0);

    // Own address, 40-byte runt
    build(48'h020000000001, 22, 1'b0);
    mark();
    send_frame(31, 0, -1, 20);
    chk("runt_count", 32'(n - b_n), 32'd22);
    chk("runt_bytes", 32'(count_bad(1'b0, b_n, 22, 22)), 32'd0);
    chk("runt_done",  32'(dones - b_d), 32'd1);
    chk("runt_err",   32'(errs - b_e), 32'd1);

    // 64-byte frame plus one stray dibit
    build(48'h020000000001, 46, 1'b0);
    mark();
    send_frame(31, 1, -1, 20);
    chk("align_count", 32'(n - b_n), 32'd46);
    chk("align_done",  32'(dones - b_d), 32'd1);
    chk("align_err",   32'(errs - b_e), 32'd1);

    // Short preamble, then a clean frame
    mark();
    send_frame(4, 0, -1, 20);
    chk("pre_count", 32'(n - b_n), 32'd0);
    chk("pre_done",  32'(dones - b_d), 32'd0);
    mark();
    send_frame(31, 0, -1, 20);
    chk("post_pre_count", 32'(n - b_n), 32'd46);
    chk("post_pre_done",  32'(dones - b_d), 32'd1);
    chk("post_pre_err",   32'(errs - b_e), 32'd0);

    // Reset at payload byte 20
    mark();
    send_frame(31, 0, 34, 0);
    chk("rst_mid_byte",  32'(rx_if.Rx_Byte), 32'h0);
    chk("rst_mid_valid", 32'(rx_if.Rx_Byte_Valid), 32'h0);
    chk("rst_mid_len",   32'(rx_if.Rx_Len_Type), 32'h0);
    repeat (20) @(negedge Clk);
    chk("rst_mid_done",  32'(dones - b_d), 32'd0);

    mark();
    send_frame(31, 0, -1, 20);
    chk("after_rst_count", 32'(n - b_n), 32'd46);
    chk("after_rst_bytes", 32'(count_bad(1'b0, b_n, 46, 46)), 32'd0);
    chk("after_rst_done",  32'(dones - b_d), 32'd1);
    chk("after_rst_err",   32'(errs - b_e), 32'd0);
    chk("after_rst_len",   32'(rx_if.Rx_Len_Type), 32'h0800);

    // Back-to-back with 12-byte IFG
    mark();
    send_frame(31, 0, -1, 48);
    send_frame(31, 0, -1, 20);
    chk("b2b_count", 32'(n - b_n), 32'd92);
    chk("b2b_bytes", 32'(count_bad(1'b0, b_n, 92, 46)), 32'd0);
    chk("b2b_done",  32'(dones - b_d), 32'd2);
    chk("b2b_err",   32'(errs - b_e), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
